audio_dac_i2s_tx: RTL and testbench
===================================

// Module: audio_dac_i2s_tx
// PURPOSE
//  I2S transmitter returning processed audio (LMS canceller output) to the codec DAC.
//  Accepts parallel L/R sample pairs via valid/ready and buffers one pair.
//  Generates bit clock and LR clock from clk and serializes MSB-first, I2S format (1-BCLK delay).
// PARAMETERS
//  DATA_W     16  sample width, two's complement; DATA_W <= SLOT_BITS
//  SLOT_BITS  16  BCLK periods per channel slot; frame = 2*SLOT_BITS BCLKs
//  BCLK_HALF  16  clk cycles per BCLK half-period (>=2); 50 MHz/32/32 = 48.8 kHz frame rate
// PORTS
//  clk            in   1       system clock
//  AUD_DACLRCK    in   1       reset, asynchronous, active-high
//  enable         in   1       run serializer; 0 = idle/abort
//  sample_valid   in   1       sample pair offered
//  sample_ready   out  1       holding register empty
//  sample_l       in   DATA_W  left sample
//  sample_r       in   DATA_W  right sample
//  clear_underrun in   1       clears underrun flag and counter
//  dac_bclk       out  1       bit clock to codec
//  dac_lrck       out  1       0 = left slot, 1 = right slot
//  dac_dat        out  1       serial data, changes on BCLK falling edge
//  frame_start    out  1       1-clk pulse when a frame is loaded
//  underrun       out  1       sticky: a frame was loaded with holding register empty
//  underrun_cnt   out  16      saturating count of underrun frames
// BEHAVIOUR
//  Reset: every register clears; dac_bclk=dac_lrck=dac_dat=0, frame_start=0, underrun=0,
//   underrun_cnt=0, holding empty so sample_ready=1. Counters start at 0 on release.
//  Divider: div_cnt 0..BCLK_HALF-1 counts while enable; dac_bclk toggles at terminal count.
//  "Fall" = clk cycle where dac_bclk goes 1->0; all dac_dat/dac_lrck updates happen only at a fall.
//  bit_cnt 0..2*SLOT_BITS-1 advances each fall, wraps to 0; dac_lrck = (bit_cnt >= SLOT_BITS).
//  Frame load: at the fall where bit_cnt becomes 0, shift frame <= {L,pad0,R,pad0}
//   (each channel MSB-aligned in its slot, LSBs zero-padded); frame_start pulses 1 clk.
//  Output: at bit_cnt=k>0, dac_dat = frame bit k-1 (bit 0 = left MSB); at k=0 dac_dat =
//   last bit of previous frame (0 after reset/enable). Left MSB 1 BCLK after dac_lrck falls.
//  Handshake: transfer when sample_valid && sample_ready; holding full -> sample_ready=0.
//   Holding empties on the frame-load cycle. Data must stay stable only in the transfer cycle.
//  Latency: pair accepted before a load goes out in that frame; left MSB appears on
//   dac_dat exactly 1 BCLK period (2*BCLK_HALF clk) after frame_start.
//  Underrun: holding empty at load -> frame per CONFIGURATION, underrun=1,
//   underrun_cnt+1 (saturates 16'hFFFF).
//  Simultaneous write and load with holding empty: the write is captured into holding,
//   the frame counts as an underrun (no bypass).
//  clear_underrun coincident with an underrun: clear wins; the flag stays 0 and the count stays 0.
//  enable=0: div_cnt/bit_cnt cleared, dac_bclk=dac_lrck=dac_dat=0, frame discarded,
//   holding register and handshake still operate. On re-enable, first fall loads a frame (bit_cnt 0).
//  Reset asserted mid-frame aborts instantly; holding contents are lost.
// CONFIGURATION
//  DAC_UNDERRUN_HOLD_EN defined: underrun frame repeats the last successfully loaded pair
//   (zeros if none since reset).
//  Not defined: underrun frame transmits all zeros (mute). Flag/counter identical in both.
// TESTING  (BCLK_HALF=2, SLOT_BITS=16, DATA_W=16; frame = 128 clk)
//  Reset: assert AUD_DACLRCK mid-frame -> all outputs 0, sample_ready=1 same cycle, no clk needed.
//  Single pair L=16'h8001 R=16'h7FFE before first load -> dac_dat bits 1..16 = 1000...0001,
//   bits 17..32 = 0111...1110, dac_lrck 0 for 16 BCLKs then 1, underrun=0.
//  Back-pressure: offer 3 pairs back-to-back -> first accepted, ready=0 until frame_start,
//   second accepted right after load; pairs appear in order, none dropped.
//  Underrun: no data for 2 frames after L=16'h1234 -> underrun=1, underrun_cnt=2; dac_dat
//   repeats 1234 (macro) or zeros (no macro); clear_underrun -> cnt=0.
//  Enable toggle: drop enable at bit_cnt=9 -> bclk/lrck/dat low next cycle; re-enable ->
//   frame_start at first fall, new frame starts at left MSB.
//  Saturation: force 65540 underruns (or preload) -> underrun_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/audio_dac_i2s_tx.sv
// I2S transmitter to the codec DAC: one-pair holding register, BCLK/LRCK generation, MSB-first serializer.
// Define DAC_UNDERRUN_HOLD_EN to repeat the last loaded pair on underrun instead of muting.
module audio_dac_i2s_tx #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SLOT_BITS = 16,
  parameter int unsigned BCLK_HALF = 16
) (
  input  logic              clk,
  input  logic              AUD_DACLRCK,
  input  logic              enable,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              clear_underrun,
  output logic              dac_bclk,
  output logic              dac_lrck,
  output logic              dac_dat,
  output logic              frame_start,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  typedef enum logic {ST_PRIME, ST_RUN} run_state_t;

  run_state_t              state_q, state_d;
  logic [DIV_W-1:0]        div_cnt;
  logic [BIT_W-1:0]        bit_cnt, bit_nxt;
  logic [FRAME_BITS-1:0]   frame_sr;
  logic                    hold_full;
  logic [DATA_W-1:0]       hold_l, hold_r;
  logic [DATA_W-1:0]       src_l, src_r;
  logic                    div_tc, fall, load, transfer;
`ifdef DAC_UNDERRUN_HOLD_EN
  logic [DATA_W-1:0]       last_l, last_r;
`endif

  // Left-justify a sample in its slot, zero-padding the LSBs.
  function automatic logic [SLOT_BITS-1:0] slot_align(input logic [DATA_W-1:0] s);
    logic [SLOT_BITS+DATA_W-1:0] t;
    t = {s, {SLOT_BITS{1'b0}}};
    return t[SLOT_BITS+DATA_W-1 -: SLOT_BITS];
  endfunction

  assign sample_ready = ~hold_full;
  assign transfer     = sample_valid & ~hold_full;

  // First fall after reset/enable loads a frame with bit_cnt held at 0.
  always_comb begin
    state_d = state_q;
    div_tc  = (div_cnt == DIV_W'(BCLK_HALF - 1));
    fall    = enable & div_tc & dac_bclk;
    bit_nxt = '0;
    load    = 1'b0;
    if (!enable) begin
      state_d = ST_PRIME;
    end else if (fall) begin
      state_d = ST_RUN;
      if (state_q == ST_RUN && bit_cnt != BIT_W'(FRAME_BITS - 1))
        bit_nxt = bit_cnt + BIT_W'(1);
      load = (bit_nxt == '0);
    end
  end

  always_comb begin
    src_l = hold_l;
    src_r = hold_r;
    if (!hold_full) begin
`ifdef DAC_UNDERRUN_HOLD_EN
      src_l = last_l;
      src_r = last_r;
`else
      src_l = '0;
      src_r = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      state_q     <= ST_PRIME;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      dac_bclk    <= 1'b0;
      dac_lrck    <= 1'b0;
      dac_dat     <= 1'b0;
      frame_sr    <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_start <= load;
      if (!enable) begin
        div_cnt  <= '0;
        bit_cnt  <= '0;
        dac_bclk <= 1'b0;
        dac_lrck <= 1'b0;
        dac_dat  <= 1'b0;
        frame_sr <= '0;
      end else begin
        div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
        if (div_tc)
          dac_bclk <= ~dac_bclk;
        if (fall) begin
          bit_cnt  <= bit_nxt;
          dac_lrck <= (bit_nxt >= BIT_W'(SLOT_BITS));
          // At k=0 the old frame's last bit is still at the top of the shifter.
          dac_dat  <= frame_sr[FRAME_BITS-1];
          frame_sr <= load ? {slot_align(src_l), slot_align(src_r)}
                           : {frame_sr[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      if (load)
        hold_full <= transfer;
      else if (transfer)
        hold_full <= 1'b1;
      if (transfer) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
      end
    end
  end

`ifdef DAC_UNDERRUN_HOLD_EN
  always_ff @(posedge clk or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      last_l <= '0;
      last_r <= '0;
    end else if (load && hold_full) begin
      last_l <= hold_l;
      last_r <= hold_r;
    end
  end
`endif

  always_ff @(posedge clk or posedge AUD_DACLRCK) begin
    if (AUD_DACLRCK) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (clear_underrun) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (load && !hold_full) begin
      underrun <= 1'b1;
      if (underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Scoreboard bench for audio_dac_i2s_tx: frame-level reference model feeds expected frames to a serial monitor.
module tb_audio_dac_i2s_tx;
  localparam int unsigned DW = 16, S = 16, BH = 2, FB = 2 * S;

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, sample_valid = 1'b0, clear_underrun = 1'b0;
  logic [DW-1:0] sample_l = '0, sample_r = '0;
  logic sample_ready, dac_bclk, dac_lrck, dac_dat, frame_start, underrun;
  logic [15:0] underrun_cnt;
  int unsigned checks = 0, errors = 0;

  audio_dac_i2s_tx #(.DATA_W(DW), .SLOT_BITS(S), .BCLK_HALF(BH)) dut (
    .clk(clk), .AUD_DACLRCK(rst), .enable(enable),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_l(sample_l), .sample_r(sample_r), .clear_underrun(clear_underrun),
    .dac_bclk(dac_bclk), .dac_lrck(dac_lrck), .dac_dat(dac_dat),
    .frame_start(frame_start), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time in edges since enable, frames as {L,R} words, holding as a queue of depth 1.
  typedef logic [FB-1:0] frame_t;
  frame_t hold_q[$], exp_q[$];
  frame_t m_last = '0, m_fr = '0;
  int unsigned m_en_cnt = 0, m_fall_cnt = 0;
  bit m_fall = 0, m_load = 0, m_unf = 0, m_acc = 0, m_under = 0;
  logic [15:0] m_cnt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en_cnt = 0; m_fall_cnt = 0; m_fall = 0; m_load = 0; m_acc = 0;
      hold_q.delete(); exp_q.delete();
      m_last = '0; m_unf = 0; m_cnt = '0;
    end else begin
      m_acc  = sample_valid && (hold_q.size() == 0);
      m_fall = 0;
      m_load = 0;
      if (!enable) begin
        m_en_cnt = 0; m_fall_cnt = 0;
      end else begin
        m_en_cnt++;
        if (m_en_cnt % (2 * BH) == 0) begin
          m_fall = 1;
          m_fall_cnt++;
          m_load = ((m_fall_cnt - 1) % FB) == 0;
        end
      end
      m_under = 0;
      if (m_load) begin
        if (hold_q.size() > 0) begin
          m_fr = hold_q.pop_front();
          m_last = m_fr;
        end else begin
          m_under = 1;
`ifdef DAC_UNDERRUN_HOLD_EN
          m_fr = m_last;
`else
          m_fr = '0;
`endif
        end
        exp_q.push_back(m_fr);
      end
      if (clear_underrun) begin
        m_unf = 0; m_cnt = '0;
      end else if (m_under) begin
        m_unf = 1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (m_acc) hold_q.push_back({sample_l, sample_r});
    end
  end

  // Monitor: per-cycle output checks plus serial frame reassembly against the scoreboard queue.
  bit mon_on = 0, coll_act = 0;
  frame_t coll_exp = '0, coll_got = '0;
  int unsigned coll_pos = 0;

  always @(negedge clk) if (mon_on) begin
    chk("sample_ready", 32'(sample_ready), 32'(hold_q.size() == 0));
    chk("frame_start", 32'(frame_start), 32'(m_load));
    chk("underrun", 32'(underrun), 32'(m_unf));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    chk("dac_bclk", 32'(dac_bclk), (m_en_cnt / BH) % 2);
    chk("dac_lrck", 32'(dac_lrck), 32'(m_fall_cnt != 0 && ((m_fall_cnt - 1) % FB) >= S));
    if (m_en_cnt == 0) begin
      coll_act = 0;
      chk("dac_dat_idle", 32'(dac_dat), 32'd0);
    end
    if (m_fall && coll_act) begin
      coll_pos++;
      coll_got[FB - coll_pos] = dac_dat;
      if (coll_pos == FB) begin
        chk("frame_bits", coll_got, coll_exp);
        coll_act = 0;
      end
    end
    if (frame_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got frame_start expected none at %0t", $time);
      end else begin
        coll_exp = exp_q.pop_front();
        coll_act = 1;
        coll_pos = 0;
        coll_got = '0;
      end
      if (m_fall_cnt == 1) chk("dat_first_k0", 32'(dac_dat), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int unsigned n = 0;
    bit acc = 0;
    sample_valid = 1'b1; sample_l = l; sample_r = r;
    while (!acc && n < 4000) begin
      acc = sample_ready;
      tick();
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no handshake expected accept within 4000 cycles");
    end
    sample_valid = 1'b0;
    sample_l = DW'($urandom);
    sample_r = DW'($urandom);
  endtask

  task automatic wait_frames(input int unsigned n);
    int unsigned seen = 0, cyc = 0;
    while (seen < n && cyc < n * 200 + 400) begin
      tick();
      cyc++;
      if (frame_start) seen++;
    end
    checks++;
    if (seen < n) begin
      errors++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", seen, n);
    end
  endtask

  task automatic pulse_clear();
    clear_underrun = 1'b1;
    tick();
    clear_underrun = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned guard;
    #1 rst = 1'b1;
    mon_on = 1;
    repeat (3) tick();
    rst = 1'b0;

    // Single pair ahead of the first load.
    send(16'h8001, 16'h7FFE);
    enable = 1'b1;
    wait_frames(2);
    pulse_clear();

    // Three pairs offered back-to-back.
    send(16'hA5A5, 16'h0F0F);
    send(16'h1357, 16'hFDB9);
    send(16'h4000, 16'hC001);
    wait_frames(4);

    // Underrun after one pair, then clear.
    clear_underrun = 1'b1;
    send(16'h1234, 16'hABCD);
    clear_underrun = 1'b0;
    wait_frames(3);
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("underrun_cnt_two", 32'(underrun_cnt), 32'd2);
    pulse_clear();
    chk("underrun_cnt_cleared", 32'(underrun_cnt), 32'd0);

    // Clear held across underrun loads keeps flag and count at zero.
    clear_underrun = 1'b1;
    repeat (300) tick();
    chk("clear_wins_flag", 32'(underrun), 32'd0);
    chk("clear_wins_cnt", 32'(underrun_cnt), 32'd0);
    clear_underrun = 1'b0;

    // Drop enable at bit 9, queue a pair while idle, re-enable.
    send(16'h9ABC, 16'h5678);
    guard = 0;
    while ((m_fall_cnt == 0 || ((m_fall_cnt - 1) % FB) != 9) && guard < 400) begin
      tick();
      guard++;
    end
    enable = 1'b0;
    tick();
    chk("dis_bclk", 32'(dac_bclk), 32'd0);
    chk("dis_lrck", 32'(dac_lrck), 32'd0);
    chk("dis_dat", 32'(dac_dat), 32'd0);
    repeat (10) tick();
    send(16'hCAFE, 16'hBEEF);
    repeat (5) tick();
    enable = 1'b1;
    wait_frames(2);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 6) send(DW'($urandom), DW'($urandom));
      else if (sel < 8) repeat ($urandom_range(1, 200)) tick();
      else if (sel == 8) pulse_clear();
      else begin
        enable = 1'b0;
        repeat ($urandom_range(1, 20)) tick();
        enable = 1'b1;
      end
    end
    wait_frames(2);

    // Asynchronous reset mid-frame.
    send(16'h7777, 16'h8888);
    repeat (37) tick();
    rst = 1'b1;
    #1;
    chk("rst_bclk", 32'(dac_bclk), 32'd0);
    chk("rst_lrck", 32'(dac_lrck), 32'd0);
    chk("rst_dat", 32'(dac_dat), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_cnt", 32'(underrun_cnt), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    send(16'h0123, 16'hFEDC);
    wait_frames(2);

    // Counter saturation from a preloaded value.
    tick();
    force dut.underrun_cnt = 16'hFFFD;
    m_cnt = 16'hFFFD;
    #1;
    release dut.underrun_cnt;
    wait_frames(4);
    chk("cnt_saturated", 32'(underrun_cnt), 32'h0000FFFF);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
